// File: rtl/gray_image_host.sv
// gray_image_host
//   Memory-side responder for the LBP engine. Loads a 128x128 8-bit image
//   from a raster byte stream, serves zero-latency reads of that image to the
//   engine, captures the engine's LBP result writes, and after `finish`
//   streams the full result image out on a valid/ready port.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   load_valid/data/ready      raster input stream (address 0 first)
//   gray_ready                 image loaded, engine may start
//   gray_req/addr/data         engine read port, gray_data combinational
//   lbp_valid/addr/data        engine result write port
//   finish                     engine done pulse
//   res_valid/ready/data/last  result output stream, res_last on final pixel
//   done                       result stream fully drained
//   err                        sticky protocol error
//
// Build option
//   LBP_WRITE_CHECK_EN  when defined, err flags protocol violations;
//                       otherwise err is tied low and no checker exists.

module gray_image_host #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {LOAD, SERVE, DRAIN, IDLE} state_t;

  state_t state_reg, state_next;
  logic [AW-1:0] load_cnt_reg;
  logic [AW-1:0] drain_cnt_reg;

  logic [DW-1:0] gray_mem [DEPTH];
  logic [DW-1:0] lbp_mem  [DEPTH];

  logic          load_fire;
  logic          res_fire;
  logic          lbp_we;
  logic [AW-1:0] lbp_wa;
  logic [DW-1:0] lbp_wd;

  assign load_fire = (state_reg == LOAD) && load_valid;
  assign res_fire  = (state_reg == DRAIN) && res_ready;

  // lbp_mem has a single write port: during LOAD it is cleared in step with
  // the image so unwritten (border) results drain as zero; during SERVE it
  // takes the engine's writes.
  always_comb begin
    lbp_we = 1'b0;
    lbp_wa = lbp_addr;
    lbp_wd = lbp_data;
    if (load_fire) begin
      lbp_we = 1'b1;
      lbp_wa = load_cnt_reg;
      lbp_wd = '0;
    end else if (state_reg == SERVE && lbp_valid) begin
      lbp_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) gray_mem[load_cnt_reg] <= load_data;
    if (lbp_we)    lbp_mem[lbp_wa]        <= lbp_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= LOAD;
      load_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Counters wrap to 0 exactly on their final beat, which is also the
      // phase change, so no explicit clear is needed.
      if (load_fire) load_cnt_reg  <= load_cnt_reg + 1'b1;
      if (res_fire)  drain_cnt_reg <= drain_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    gray_data  = '0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_last   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      LOAD: begin
        load_ready = 1'b1;
        if (load_fire && load_cnt_reg == LAST_ADDR) state_next = SERVE;
      end
      SERVE: begin
        gray_ready = 1'b1;
        // The engine samples gray_data in the same cycle it drives the
        // address, so this read must be purely combinational.
        if (gray_req) gray_data = gray_mem[gray_addr];
        if (finish) state_next = DRAIN;
      end
      DRAIN: begin
        res_valid = 1'b1;
        res_data  = lbp_mem[drain_cnt_reg];
        res_last  = (drain_cnt_reg == LAST_ADDR);
        if (res_fire && drain_cnt_reg == LAST_ADDR) state_next = IDLE;
      end
      default: begin
        done = 1'b1;
      end
    endcase
  end

`ifdef LBP_WRITE_CHECK_EN
  localparam int HALF = AW / 2;
  localparam int SIDE = 1 << HALF;
  // Only interior pixels get an LBP code, so a complete run writes
  // (SIDE-2)^2 results before finishing.
  localparam logic [AW-1:0] REQ_WRITES = AW'((SIDE - 2) * (SIDE - 2));

  logic          err_reg;
  logic [AW-1:0] wr_cnt_reg;
  logic [HALF-1:0] lbp_row, lbp_col;
  logic          border;
  logic          err_hit;

  assign lbp_row = lbp_addr[AW-1:HALF];
  assign lbp_col = lbp_addr[HALF-1:0];
  assign border  = (lbp_row == '0) || (lbp_row == '1) ||
                   (lbp_col == '0) || (lbp_col == '1);

  assign err_hit = (lbp_valid && state_reg != SERVE) ||
                   (lbp_valid && border) ||
                   (gray_req && state_reg != SERVE) ||
                   (state_reg == SERVE && finish && wr_cnt_reg < REQ_WRITES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_reg    <= 1'b0;
      wr_cnt_reg <= '0;
    end else begin
      if (err_hit) err_reg <= 1'b1;
      // Saturate so a runaway engine cannot wrap the count back below the
      // threshold.
      if (state_reg == SERVE && lbp_valid && wr_cnt_reg != '1)
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/gray_image_host.md
Name: gray_image_host

Overview:
- Memory-side responder for the LBP engine's gray-image read and LBP-result write interfaces.
- Accepts a 128x128 8-bit image as a raster byte stream and raises gray_ready.
- Serves zero-latency gray_addr reads and captures lbp_valid writes into a result buffer.
- After finish, streams the full 128x128 result image out on a valid/ready port.

Parameters:
- AW, 14, pixel address width (row in [13:7], col in [6:0]); image size is 2^AW = 16384 pixels.
- DW, 8, pixel/result data width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- load_valid  in  1  input stream byte valid
- load_data  in  DW  input pixel, raster order starting at address 0
- load_ready  out  1  block accepts load_data
- gray_ready  out  1  image loaded; engine may start
- gray_req  in  1  engine read request
- gray_addr  in  AW  engine read address
- gray_data  out  DW  read data, combinational from gray_addr
- lbp_valid  in  1  result write strobe
- lbp_addr  in  AW  result write address
- lbp_data  in  DW  result write data
- finish  in  1  engine done pulse
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  DW  result pixel, raster order
- res_last  out  1  marks address 16383 on the result stream
- done  out  1  drain complete
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Storage: gray_mem and lbp_mem, 2^AW x DW each.
- State machine: LOAD -> SERVE -> DRAIN -> IDLE.
- Reset (reset==0 at a clock edge): state=LOAD, load_cnt=0, drain_cnt=0, err=0.
- Output reset values: load_ready=1 (LOAD), gray_ready=0, res_valid=0, res_last=0, done=0, gray_data=0.
- Reset mid-operation abandons the current phase. Memory contents are not cleared by reset.
- LOAD:
  - load_ready=1.
  - On load_valid&&load_ready: gray_mem[load_cnt]<=load_data, lbp_mem[load_cnt]<=0, load_cnt++. This zeroing guarantees border pixels read back as 0.
  - When the byte at load_cnt==16383 is accepted: next state SERVE, load_cnt wraps to 0.
  - lbp_valid, gray_req and finish are ignored in LOAD.
- SERVE:
  - gray_ready=1 and load_ready=0.
  - gray_data = gray_req ? gray_mem[gray_addr] : 0. Purely combinational, zero-cycle latency, because the engine samples gray_data in the same cycle it drives gray_addr.
  - On lbp_valid: lbp_mem[lbp_addr]<=lbp_data at that edge. Last write to the same address wins.
  - finish==1: next state DRAIN. If lbp_valid and finish are high in the same cycle, the write is still committed.
- DRAIN:
  - gray_ready=0.
  - res_valid=1, res_data=lbp_mem[drain_cnt] (combinational read), res_last=(drain_cnt==16383).
  - Handshake: on res_valid&&res_ready, drain_cnt++. res_data must stay stable while res_ready==0.
  - Last beat accepted: next state IDLE.
  - lbp_valid is ignored in DRAIN.
- IDLE:
  - done=1 and all other handshake outputs are 0.
  - Remains in IDLE until reset.
- Counters are AW bits wide; wrap from 16383 to 0 is permitted only at a phase transition.

Optional Feature:
- Macro: LBP_WRITE_CHECK_EN.
- With the macro defined, err becomes sticky 1 (cleared only by reset) on any of:
  - lbp_valid outside SERVE;
  - lbp_valid with a border address (row 0/127 or col 0/127);
  - gray_req outside SERVE;
  - finish in SERVE before 15876 (126x126) lbp_valid writes have been counted.
  A 14-bit write counter supports the last check.
- Without the macro: err is tied to 0, no checker logic is synthesized, and all functional behaviour is otherwise identical.

Test Plan:
- Reset then stream 16384 bytes with data=addr[7:0] -> gray_ready rises on the cycle after the last accept; with gray_req=1, gray_addr=0x0081, gray_data=0x81 in the same cycle.
- Load with load_valid toggling every other cycle -> exactly 16384 accepts; load_ready drops only after the last one; gray_mem[0x3FFF]=0xFF.
- In SERVE, write lbp_addr=0x0081/0xA5 and 0x0081/0x3C back-to-back, then finish -> drain beat 129 = 0x3C; beats 0 and 16383 = 0x00; res_last only on beat 16383; done=1 after it.
- Hold res_ready low for 5 cycles mid-drain at drain_cnt=200 -> res_data stable, drain_cnt stays at 200 until a handshake occurs.
- Assert reset=0 for one cycle mid-SERVE -> state LOAD, gray_ready=0, load_ready=1 on the next cycle.
- With LBP_WRITE_CHECK_EN defined: lbp_valid at address 0x0000 during SERVE -> err=1 on the next cycle and held until reset; without the macro, the same stimulus -> err=0.
